// File: rtl/ps2_rx_controller_if.sv
// Key-event handshake between the PS/2 receiver (master) and the consumer (slave).
interface ps2_rx_controller_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_break,
        output evt_ext,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_break,
        input  evt_ext,
        output evt_ready
    );
endinterface

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: synchronizer, frame FSM, E0/F0 prefix merge and event FIFO.
// Optional frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_rx_controller #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    ps2_rx_controller_if.master         evt,
    output logic                        frame_err,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic                        busy
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   ps2_clk_s, ps2_data_s, fall;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       parity_q;
    logic       byte_done_q;
    logic       frame_err_q;
    logic       wd_abort;

    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       push_q, push_d;
    logic [9:0] push_data_q, push_data_d;

    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [9:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, pop, push_ok;
    logic [9:0]       head;

    // Sync and edge-history flops idle high so reset release never looks like a fall.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;

`ifdef PS2_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if ((state_q == IDLE) || fall)
            wd_cnt_d = '0;
        else if (wd_cnt_q != WD_LIMIT)
            wd_cnt_d = wd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt_q <= '0;
        else
            wd_cnt_q <= wd_cnt_d;
    end

    assign wd_abort = (state_q != IDLE) && !fall && (wd_cnt_q == WD_LIMIT);
`else
    // Without the watchdog an open frame waits forever for its next edge.
    assign wd_abort = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (wd_abort) begin
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                shreg_q     <= '0;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!ps2_data_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg_q[bit_cnt_q] <= ps2_data_s;
                        if (bit_cnt_q == 3'd7)
                            state_q <= PARITY;
                        else
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    PARITY: begin
                        parity_q <= ps2_data_s;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        // Odd parity: data bits plus parity bit must XOR to 1.
                        if (ps2_data_s && ((^shreg_q) ^ parity_q))
                            byte_done_q <= 1'b1;
                        else
                            frame_err_q <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (wd_abort) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_done_q) begin
            if (shreg_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                push_d      = 1'b1;
                push_data_d = {ext_pend_q, brk_pend_q, shreg_q};
                ext_pend_d  = 1'b0;
                brk_pend_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    // A full FIFO still takes a push when the head is popped in the same cycle.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign pop     = !empty && evt.evt_ready;
    assign push_ok = push_q && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = push_data_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_q && !push_ok)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign head          = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign evt.evt_valid = !empty;
    assign evt.evt_code  = head[7:0];
    assign evt.evt_break = head[8];
    assign evt.evt_ext   = head[9];
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/ps2_rx_controller.md
Name: ps2_rx_controller

Overview:
- Sequences PS/2 keyboard reception in the processor clock domain.
- Synchronizes ps2_clk/ps2_data and frames each 11-bit transfer (start, 8 data LSB-first, odd parity, stop) with a state machine.
- Merges E0/F0 prefix bytes into single key events and buffers them in a small FIFO.
- The processor's memory-mapped I/O drains the FIFO through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of buffered key events (power of two, ≥2)
- SYNC_STAGES, 2, synchronizer flops on ps2_clk and ps2_data (≥2)
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before an open frame is aborted (watchdog build only)

Ports:
- clk  input  1  processor clock
- rst_n  input  1  asynchronous active-low reset
- ps2_clk  input  1  keyboard clock, asynchronous to clk
- ps2_data  input  1  keyboard data, asynchronous to clk
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head event
- evt_code  output  8  scan code of head event
- evt_break  output  1  head event is a key release (F0 prefix seen)
- evt_ext  output  1  head event is extended (E0 prefix seen)
- frame_err  output  1  one-cycle pulse on rejected frame
- overflow  output  1  sticky: event dropped because FIFO was full
- clr_overflow  input  1  synchronous clear of overflow
- busy  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk; rst_n asynchronous, active-low. Reset mid-frame discards the partial frame and any pending prefixes.
- Reset values:
  - evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, frame_err=0, overflow=0, busy=0.
  - FIFO empty, FSM IDLE.
  - Synchronizer and edge-history flops reset to 1, so releasing reset never produces a false edge.
- Edge detect: fall = previous synchronized ps2_clk 1 and current 0. ps2_data is sampled from its synchronizer in the same cycle. All FSM actions occur only on fall cycles, except the watchdog.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with data=0 → DATA, bit_cnt=0. Fall with data=1 → stay IDLE, pulse frame_err.
  - DATA: shift sample into shreg[bit_cnt]. On bit_cnt=7 → PARITY, otherwise bit_cnt+1.
  - PARITY: store parity bit → STOP.
  - STOP: frame is good if stop bit=1 and XOR(shreg, parity)=1. Good → byte_done pulse with shreg. Bad → frame_err pulse, byte discarded, prefixes kept. Either way → IDLE.
- Byte decoder, on byte_done:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte pushes {ext_pend, brk_pend, byte} and clears both pend flags.
  - Pend flags clear even if the push is dropped.
- FIFO:
  - Push is accepted the cycle after byte_done.
  - Pop when evt_valid && evt_ready. Outputs always show the head entry and hold stable while evt_valid && !evt_ready.
  - Push into an empty FIFO raises evt_valid on the following cycle.
  - Full plus push without pop: event dropped, overflow=1.
  - Full plus push with simultaneous pop: both accepted, no overflow.
  - Empty plus push: no bypass, pop is not possible the same cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Latency: ps2_clk stop-bit fall at the pin → evt_valid high in exactly SYNC_STAGES+3 clk cycles (5 at default), from an empty FIFO.
- overflow: clr_overflow clears it. Simultaneous set and clear: set wins.
- busy = (state != IDLE).

Optional Feature:
- Macro: PS2_WATCHDOG_EN.
- Defined:
  - A counter reloads to 0 on every fall and increments otherwise, saturating.
  - If state≠IDLE and the counter reaches TIMEOUT_CYCLES-1, FSM → IDLE next cycle, frame_err pulses, partial byte and pend flags are cleared.
  - The counter is not active in IDLE.
- Undefined: no counter; FSM waits indefinitely for edges; TIMEOUT_CYCLES unused.

Test Plan:
- Frame 0x1C (parity 0, stop 1), evt_ready=1 → one event code=1C break=0 ext=0; evt_valid 5 clk after the stop fall; frame_err stays 0.
- Frames F0, 1C → exactly one event code=1C break=1 ext=0; no event for F0.
- Frames E0, F0, 75 → one event code=75 break=1 ext=1; a following frame 1C → break=0 ext=0.
- Frame 0x1C with parity=1 → frame_err pulse one cycle, no event; next good frame 0x32 → event code=32.
- evt_ready=0, frames 1C,32,21,23,2B → FIFO holds 1C,32,21,23 in order, overflow=1. Drain with evt_ready=1 → those four codes only. clr_overflow → 0.
- PS2_WATCHDOG_EN: start+4 data bits then idle TIMEOUT_CYCLES → frame_err, busy=0, no event; next frame 0x1C → event code=1C. Assert rst_n=0 mid-frame → all outputs reset values, no spurious event after release.
